// File: rtl/wb_hp_pkg.sv
//------------------------------------------------------------------------------
// wb_hp_pkg
// Shared constants for the wb_hp glitch/alarm test block:
//   - Wishbone word address of the control register
//   - CTL, GPIO and status bit positions
//   - glitch generator timing (period, window start, window length)
//   - alarm counter width, plus a saturating-increment helper
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_hp_pkg;

    // Control register lives at byte address 0x3000_0000 (word 0x0C00_0000)
    localparam logic [29:0] CTL_WORD_ADR = 30'h0C00_0000;

    // CTL bits; gpio_i[3:0] use the same order
    localparam int CTL_VCC       = 0;
    localparam int CTL_ALARM_RST = 1;
    localparam int CTL_CTR_RST   = 2;
    localparam int CTL_GLITCH_EN = 3;

    // GPIO enable pins
    localparam int GPIO_OE_EN    = 14;
    localparam int GPIO_PIN_CTL  = 15;

    // Status bit positions (read data and gpio_o share them)
    localparam int ST_ALARM      = 4;
    localparam int ST_LATCH      = 5;
    localparam int ST_CTR_LSB    = 6;

    // Glitch generator timing
    localparam int PERIOD        = 16;
    localparam int GLITCH_START  = 12;
    localparam int GLITCH_LEN    = 2;
    localparam int PHASE_W       = $clog2(PERIOD);

    localparam logic [PHASE_W-1:0] WIN_LO = PHASE_W'(GLITCH_START);
    localparam logic [PHASE_W-1:0] WIN_HI = PHASE_W'(GLITCH_START + GLITCH_LEN - 1);

    // Alarm counter
    localparam int CTR_W         = 8;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == {CTR_W{1'b1}}) ? v : v + {{(CTR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/wb_hp_core.sv
//------------------------------------------------------------------------------
// hp_core
// Test-glitch generator and its alarm detector.
//   clk, rst     : clock, synchronous active-high reset
//   ctl_eff[3:0] : effective control {glitch_en, alarm_ctr_rst, alarm_rst, vcc}
//   glitch       : registered pulse, high for phases 12..13 of each 16-cycle period
//   alarm        : glitch | glitch delayed one cycle
//   alarm_latch  : sticky alarm, cleared by alarm_rst
//   alarm_ctr    : saturating count of glitch rising edges, cleared by alarm_ctr_rst
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module hp_core
    import wb_hp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ctl_eff,
    output logic             glitch,
    output logic             alarm,
    output logic             alarm_latch,
    output logic [CTR_W-1:0] alarm_ctr
);

    logic               active;
    logic               in_window;
    logic               glitch_rise;
    logic               glitch_d1;
    logic [PHASE_W-1:0] phase_p0;

    // Either reset request also parks the generator so the cleared state stays clean
    assign active = ctl_eff[CTL_VCC] & ctl_eff[CTL_GLITCH_EN]
                  & ~ctl_eff[CTL_ALARM_RST] & ~ctl_eff[CTL_CTR_RST];

    assign in_window   = (phase_p0 >= WIN_LO) && (phase_p0 <= WIN_HI);
    assign glitch_rise = glitch & ~glitch_d1;

    // Stretching by one cycle guarantees alarm is high on the falling edge of glitch
    assign alarm = glitch | glitch_d1;

    // ---- stage p0: phase counter / glitch register / detector state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_p0    <= '0;
            glitch      <= 1'b0;
            glitch_d1   <= 1'b0;
            alarm_latch <= 1'b0;
            alarm_ctr   <= '0;
        end else begin
            // Natural wrap of the phase counter gives the period
            phase_p0  <= active ? phase_p0 + PHASE_W'(1) : '0;
            glitch    <= active & in_window;
            glitch_d1 <= glitch;

            if (ctl_eff[CTL_ALARM_RST])
                alarm_latch <= 1'b0;
            else if (alarm)
                alarm_latch <= 1'b1;

            if (ctl_eff[CTL_CTR_RST])
                alarm_ctr <= '0;
            else if (glitch_rise)
                alarm_ctr <= sat_inc(alarm_ctr);
        end
    end

endmodule

// File: rtl/wb_hp.sv
//------------------------------------------------------------------------------
// wb_hp
// Wishbone-controlled test-glitch generator with alarm detection.
//   wb_clk_i, reset         : clock, synchronous active-high reset
//   user_clock2             : unused
//   wbs_cyc/stb/we/adr/dat_i: Wishbone slave request
//   wbs_ack_o               : ack one cycle after every request
//   wbs_stl_o               : tied 0
//   wbs_dat_o               : registered read data, held until the next read
//   gpio_i                  : [3:0] pin control, [14] status OE, [15] pin-control enable
//   gpio_o                  : [4] alarm, [5] alarm_latch, [13:6] alarm_ctr
//   gpio_enb                : active-low output enables, [13:4] follow gpio_i[14]
//   glitch                  : generated glitch pulse
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_hp
    import wb_hp_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        reset,
    input  logic        user_clock2,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_stl_o,
    output logic [31:0] wbs_dat_o,
    input  logic [15:0] gpio_i,
    output logic [15:0] gpio_o,
    output logic [15:0] gpio_enb,
    output logic        glitch
);

    logic [15:0]      gpio_meta_p0;
    logic [15:0]      gpio_sync_p1;
    logic [3:0]       ctl;
    logic [3:0]       ctl_eff;
    logic             wb_req;
    logic             adr_hit;
    logic             alarm;
    logic             alarm_latch;
    logic [CTR_W-1:0] alarm_ctr;
    logic [31:0]      status;
    logic             unused_bits;

    // ---- stage p0/p1: two-flop GPIO synchronizer ----
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            gpio_meta_p0 <= '0;
            gpio_sync_p1 <= '0;
        end else begin
            gpio_meta_p0 <= gpio_i;
            gpio_sync_p1 <= gpio_meta_p0;
        end
    end

    // Pins can only add control bits, never mask ones set over the bus
    assign ctl_eff = ctl | ({4{gpio_sync_p1[GPIO_PIN_CTL]}} & gpio_sync_p1[3:0]);

    assign wb_req  = wbs_cyc_i & wbs_stb_i;
    assign adr_hit = (wbs_adr_i[31:2] == CTL_WORD_ADR);
    assign status  = {{(32-ST_CTR_LSB-CTR_W){1'b0}}, alarm_ctr, alarm_latch, alarm, ctl};

    // ---- bus stage: ack, CTL write, registered read data ----
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctl       <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            if (wb_req && wbs_we_i && adr_hit)
                ctl <= wbs_dat_i[3:0];
            if (wb_req && !wbs_we_i)
                wbs_dat_o <= adr_hit ? status : '0;
        end
    end

    assign wbs_stl_o = 1'b0;

    hp_core u_core (
        .clk         (wb_clk_i),
        .rst         (reset),
        .ctl_eff     (ctl_eff),
        .glitch      (glitch),
        .alarm       (alarm),
        .alarm_latch (alarm_latch),
        .alarm_ctr   (alarm_ctr)
    );

    assign gpio_o   = {2'b00, alarm_ctr, alarm_latch, alarm, 4'b0000};
    assign gpio_enb = {2'b11, {10{~gpio_sync_p1[GPIO_OE_EN]}}, 4'hF};

    // Inputs with no function in this block
    assign unused_bits = ^{user_clock2, gpio_sync_p1[13:4], wbs_adr_i[1:0], wbs_dat_i[31:4]};

endmodule

// File: tb/tb_wb_hp.sv
`timescale 1ns/1ps
module tb_wb_hp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uc2 = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic [15:0] gpio = '0;
    logic        ack, stl, glitch;
    logic [31:0] dat_o;
    logic [15:0] gpio_o, gpio_enb;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    wb_hp dut (
        .wb_clk_i    (clk),
        .reset       (rst),
        .user_clock2 (uc2),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_stl_o   (stl),
        .wbs_dat_o   (dat_o),
        .gpio_i      (gpio),
        .gpio_o      (gpio_o),
        .gpio_enb    (gpio_enb),
        .glitch      (glitch)
    );

    always #1.1 clk = ~clk;

    // ---------------- reference model ----------------
    // Pins seen one/two edges ago, register contents, and the length of the
    // current run of "generator allowed" cycles; glitch is high whenever the
    // number of earlier cycles in the run, modulo 16, is 12 or 13.
    logic [15:0] h1 = '0, h2 = '0;
    logic [3:0]  m_ctl = '0;
    int          run_len = 0;
    logic        m_g = 0, m_gd = 0, m_latch = 0, m_ack = 0;
    logic [7:0]  m_ctr = '0;
    logic [31:0] m_dat = '0;

    typedef struct { logic rd; logic [31:0] d; } exp_t;
    exp_t sbq[$];

    task automatic model_step();
        logic [3:0]  eff;
        logic        act, alarm_now, rise, hit;
        logic [31:0] st;
        int          ph;
        if (rst) begin
            h1 = '0; h2 = '0; m_ctl = '0; run_len = 0;
            m_g = 0; m_gd = 0; m_latch = 0; m_ctr = '0; m_ack = 0; m_dat = '0;
        end else begin
            eff       = m_ctl | (h2[15] ? h2[3:0] : 4'h0);
            act       = eff[0] && eff[3] && !eff[1] && !eff[2];
            alarm_now = m_g | m_gd;
            rise      = m_g & ~m_gd;
            st        = {18'd0, m_ctr, m_latch, alarm_now, m_ctl};
            hit       = (adr >= 32'h3000_0000) && (adr <= 32'h3000_0003);
            m_ack     = cyc & stb;
            if (cyc && stb) begin
                if (we) begin
                    if (hit) m_ctl = dat[3:0];
                    sbq.push_back('{1'b0, 32'd0});
                end else begin
                    m_dat = hit ? st : 32'd0;
                    sbq.push_back('{1'b1, m_dat});
                end
            end
            ph      = run_len % 16;
            m_gd    = m_g;
            m_g     = act && (ph >= 12) && (ph < 14);
            run_len = act ? run_len + 1 : 0;
            if (eff[1]) m_latch = 0;
            else if (alarm_now) m_latch = 1;
            if (eff[2]) m_ctr = 0;
            else if (rise && m_ctr != 8'd255) m_ctr = m_ctr + 8'd1;
            h2 = h1;
            h1 = gpio;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_glitch = 0;
    initial forever begin
        @(negedge clk);
        if (checking) begin
            check("glitch",   {31'd0, glitch}, {31'd0, m_g});
            check("gpio_o",   {16'd0, gpio_o}, {16'd0, 2'b00, m_ctr, m_latch, m_g | m_gd, 4'h0});
            check("gpio_enb", {16'd0, gpio_enb}, {16'd0, 2'b11, {10{~h2[14]}}, 4'hF});
            check("ack",      {31'd0, ack}, {31'd0, m_ack});
            check("dat_hold", dat_o, m_dat);
            check("stall",    {31'd0, stl}, 32'd0);
            if (prev_glitch && !glitch)
                check("alarm_at_fall", {31'd0, gpio_o[4]}, 32'd1);
            if (ack) begin
                check("sb_nonempty", {31'd0, sbq.size() > 0}, 32'd1);
                if (sbq.size() > 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.rd) check("sb_rdata", dat_o, e.d);
                end
            end
            prev_glitch = glitch;
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = a; dat = d;
        @(negedge clk);
        check("wr_ack_next_cycle", {31'd0, ack}, 32'd1);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = a;
        @(negedge clk);
        check("rd_ack_next_cycle", {31'd0, ack}, 32'd1);
        d = dat_o;
        cyc = 0; stb = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [31:0] CTL_A = 32'h3000_0000;
    logic [31:0] rd;
    logic [15:0] g;

    initial begin
        rst = 1;
        cycles(3);
        checking = 1;
        check("rst_gpio_o", {16'd0, gpio_o}, 32'd0);
        check("rst_enb",    {16'd0, gpio_enb}, 32'h0000_FFFF);
        check("rst_ack",    {31'd0, ack}, 32'd0);
        check("rst_dat",    dat_o, 32'd0);
        check("rst_glitch", {31'd0, glitch}, 32'd0);
        rst = 0;

        // pin-driven generator: vcc + glitch_en, pin control and OE on
        gpio = 16'hC009;
        cycles(228);
        check("pin_ctr_ge8", {31'd0, gpio_o[13:6] >= 8'd8}, 32'd1);
        check("pin_latch",   {31'd0, gpio_o[5]}, 32'd1);
        check("pin_enb_on",  {16'd0, gpio_enb}, 32'h0000_C00F);

        // alarm_ctr_rst pulse from pins
        gpio = 16'hC00D;
        cycles(46);
        gpio = 16'hC009;
        cycles(6);
        check("pin_ctr_clear", {24'd0, gpio_o[13:6]}, 32'd0);

        // alarm_rst pulse from pins
        gpio = 16'hC00B;
        cycles(46);
        gpio = 16'hC009;
        cycles(6);
        check("pin_latch_clear", {31'd0, gpio_o[5]}, 32'd0);

        // bus access with pins inactive
        @(negedge clk); rst = 1; gpio = 16'h0000;
        cycles(2); rst = 0;
        wb_read(CTL_A, rd);
        check("rd_vcc0", {31'd0, rd[0]}, 32'd0);
        wb_write(CTL_A, 32'd1);
        wb_read(CTL_A, rd);
        check("rd_vcc1", {31'd0, rd[0]}, 32'd1);

        // build alarm state from CTL, then clear latch over the bus
        wb_write(CTL_A, 32'd9);
        cycles(200);
        check("ctl_latch_set", {31'd0, gpio_o[5]}, 32'd1);
        wb_write(CTL_A, 32'd3);
        cycles(46);
        wb_write(CTL_A, 32'd1);
        wb_read(CTL_A, rd);
        check("ctl_latch_clr", {31'd0, rd[5]}, 32'd0);

        // build counter, clear over the bus
        wb_write(CTL_A, 32'd9);
        cycles(200);
        check("ctl_ctr_nz", {31'd0, gpio_o[13:6] != 8'd0}, 32'd1);
        wb_write(CTL_A, 32'd5);
        cycles(46);
        wb_write(CTL_A, 32'd1);
        wb_read(CTL_A, rd);
        check("ctl_ctr_clr", {24'd0, rd[13:6]}, 32'd0);

        // undecoded address
        wb_read(32'h3000_0010, rd);
        check("undec_rd", rd, 32'd0);
        wb_write(32'h3000_0010, 32'hF);
        wb_read(CTL_A, rd);
        check("undec_wr_ctl", {28'd0, rd[3:0]}, 32'd1);

        // request in flight at reset is dropped
        @(negedge clk);
        rst = 1; cyc = 1; stb = 1; we = 0; adr = CTL_A;
        @(negedge clk);
        check("rst_drop_ack", {31'd0, ack}, 32'd0);
        rst = 0; cyc = 0; stb = 0;

        // counter saturation
        wb_write(CTL_A, 32'd9);
        cycles(4400);
        check("ctr_sat", {24'd0, gpio_o[13:6]}, 32'd255);
        wb_read(CTL_A, rd);
        check("ctr_sat_rd", {24'd0, rd[13:6]}, 32'd255);
        wb_write(CTL_A, 32'd0);

        // randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (i % 100 == 0) begin
                g = 16'($urandom);
                g[15] = ($urandom % 4) != 0;
                g[3:0] = 4'b1001 | ((($urandom % 4) == 0) ? (4'($urandom) & 4'b0110) : 4'b0000);
                gpio = g;
            end
            case ($urandom % 4)
                0, 1:    begin cyc = 1; stb = 1; end
                2:       begin cyc = 1; stb = 0; end
                default: begin cyc = 0; stb = 0; end
            endcase
            we  = $urandom % 2;
            adr = (($urandom % 4) == 0) ? $urandom : (CTL_A | ($urandom % 4));
            dat = $urandom;
            rst = (($urandom % 400) == 0);
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0; rst = 0;
        cycles(4);
        check("sb_drain", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
